// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port integer register file.
package rf_pkg;

    localparam int A_WIDTH_DEF = 5;
    localparam int D_WIDTH_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_S1   = 9;
    localparam int REG_A0   = 10;

    typedef logic [A_WIDTH_DEF-1:0] reg_addr_t;
    typedef logic [D_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback, set wins on a tie.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int NR      = 2,
    parameter int NW      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [A_WIDTH-1:0]    iss_rd,
    input  logic [NW-1:0]         we,
    input  logic [NW*A_WIDTH-1:0] wa,
    input  logic [NR*A_WIDTH-1:0] ra,
    output logic [NR-1:0]         busy
);

    localparam int DEPTH = 2 ** A_WIDTH;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NW; k++) begin
            if (we[k]) begin
                busy_d[wa[k*A_WIDTH +: A_WIDTH]] = 1'b0;
            end
        end
        // Applied after the clears so a new producer supersedes the retiring one.
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NR; gi++) begin : g_lookup
        assign busy[gi] = busy_q[ra[gi*A_WIDTH +: A_WIDTH]];
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with trigger input, a0 debug tap and busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes (and trigger) to the read ports.
module rf_mp
    import rf_pkg::*;
#(
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int TRIG_REG = REG_S1,
    parameter int DBG_REG  = REG_A0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NW-1:0]         we,
    input  logic [NW*A_WIDTH-1:0] wa,
    input  logic [NW*D_WIDTH-1:0] wd,
    input  logic [NR*A_WIDTH-1:0] ra,
    output logic [NR*D_WIDTH-1:0] rd,
    output logic [NR-1:0]         rbusy,
    input  logic                  iss_valid,
    input  logic [A_WIDTH-1:0]    iss_rd,
    input  logic                  trigger,
    output logic [D_WIDTH-1:0]    dbg_o
);

    localparam int                 DEPTH    = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] ZERO_A   = A_WIDTH'(REG_ZERO);
    localparam logic [A_WIDTH-1:0] TRIG_A   = A_WIDTH'(TRIG_REG);
    localparam logic [A_WIDTH-1:0] DBG_A    = A_WIDTH'(DBG_REG);
    localparam logic [D_WIDTH-1:0] TRIG_VAL = D_WIDTH'(1);
    localparam bit                 TRIG_ON  = (TRIG_REG != REG_ZERO);

    if (A_WIDTH < 1 || D_WIDTH < 1) begin : g_bad_width
        $error("rf_mp: A_WIDTH and D_WIDTH must be at least 1");
    end
    if (NR < 1 || NR > 4) begin : g_bad_nr
        $error("rf_mp: NR must be in 1..4");
    end
    if (NW < 1 || NW > 2) begin : g_bad_nw
        $error("rf_mp: NW must be in 1..2");
    end
    if (TRIG_REG < 0 || TRIG_REG >= DEPTH || DBG_REG < 0 || DBG_REG >= DEPTH) begin : g_bad_reg
        $error("rf_mp: TRIG_REG and DBG_REG must address an existing register");
    end

    logic [D_WIDTH-1:0] regs_q [DEPTH];
    logic [D_WIDTH-1:0] regs_d [DEPTH];
    logic [NR-1:0]      sb_busy;

    always_comb begin
        regs_d = regs_q;
        if (trigger && TRIG_ON) begin
            regs_d[TRIG_A] = TRIG_VAL;
        end
        // Ascending order: the highest-indexed port writing an address wins.
        for (int k = 0; k < NW; k++) begin
            if (we[k]) begin
                regs_d[wa[k*A_WIDTH +: A_WIDTH]] = wd[k*D_WIDTH +: D_WIDTH];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .A_WIDTH (A_WIDTH),
        .NR      (NR),
        .NW      (NW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .wa        (wa),
        .ra        (ra),
        .busy      (sb_busy)
    );

    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
        logic [A_WIDTH-1:0] ra_i;
        logic [D_WIDTH-1:0] rd_i;
        logic               byp_hit;

        assign ra_i = ra[gi*A_WIDTH +: A_WIDTH];

        always_comb begin
            rd_i    = regs_q[ra_i];
            byp_hit = 1'b0;
`ifdef RF_BYPASS_EN
            // Forwarding is suppressed while in reset so outputs read as zero.
            if (rst_n && ra_i != ZERO_A) begin
                if (trigger && TRIG_ON && ra_i == TRIG_A) begin
                    rd_i = TRIG_VAL;
                end
                for (int k = 0; k < NW; k++) begin
                    if (we[k] && wa[k*A_WIDTH +: A_WIDTH] == ra_i) begin
                        rd_i    = wd[k*D_WIDTH +: D_WIDTH];
                        byp_hit = 1'b1;
                    end
                end
            end
`endif
            if (ra_i == ZERO_A) begin
                rd_i = '0;
            end
        end

        assign rd[gi*D_WIDTH +: D_WIDTH] = rd_i;
        assign rbusy[gi]                 = sb_busy[gi] & ~byp_hit;
    end

    assign dbg_o = regs_q[DBG_A];

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp (NR=2, NW=2) with a behavioural register-file model.
module tb_rf_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NW-1:0]     we = '0;
    logic [NW*AW-1:0]  wa = '0;
    logic [NW*DW-1:0]  wd = '0;
    logic [NR*AW-1:0]  ra = '0;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rbusy;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_rd = '0;
    logic              trigger = 1'b0;
    logic [DW-1:0]     dbg_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl   [32];
    logic          mbusy [32];

    always #5 clk = ~clk;

    rf_mp #(
        .A_WIDTH  (AW),
        .D_WIDTH  (DW),
        .NR       (NR),
        .NW       (NW),
        .TRIG_REG (9),
        .DBG_REG  (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .ra        (ra),
        .rd        (rd),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .trigger   (trigger),
        .dbg_o     (dbg_o)
    );

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end else begin
            $display("ok   %s = %h t=%0t", nm, got, $time);
        end
    endtask

    function automatic int wa_of(input int k);
        return int'(wa[k*AW +: AW]);
    endfunction

    // Register value after the coming edge: last writer by port index, else trigger, else hold.
    function automatic logic [DW-1:0] next_val(input int r);
        for (int k = NW - 1; k >= 0; k--) begin
            if (we[k] && wa_of(k) == r) return wd[k*DW +: DW];
        end
        if (trigger && r == 9) return 32'd1;
        return mdl[r];
    endfunction

    function automatic logic next_busy(input int r);
        if (iss_valid && int'(iss_rd) == r) return 1'b1;
        for (int k = 0; k < NW; k++) begin
            if (we[k] && wa_of(k) == r) return 1'b0;
        end
        return mbusy[r];
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (rst_n) return next_val(a);
`endif
        return mdl[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (rst_n) begin
            for (int k = 0; k < NW; k++) begin
                if (we[k] && wa_of(k) == a) return 1'b0;
            end
        end
`endif
        return mbusy[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                mdl[r]   <= '0;
                mbusy[r] <= 1'b0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                mdl[r]   <= next_val(r);
                mbusy[r] <= next_busy(r);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            int a;
            a = int'(ra[i*AW +: AW]);
            chk($sformatf("cmp_rd%0d[x%0d]", i, a), rd[i*DW +: DW], exp_rd(a));
            chk($sformatf("cmp_busy%0d[x%0d]", i, a), DW'(rbusy[i]), DW'(exp_busy(a)));
        end
        chk("cmp_dbg", dbg_o, mdl[10]);
    end

    task automatic idle();
        we = '0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0; trigger = 1'b0;
    endtask

    task automatic wr(input int k, input int a, input logic [DW-1:0] v);
        we[k] = 1'b1;
        wa[k*AW +: AW] = AW'(a);
        wd[k*DW +: DW] = v;
    endtask

    task automatic rdsel(input int i, input int a);
        ra[i*AW +: AW] = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #3;
        chk("reset_rd0", rd[DW-1:0], 32'h0);
        chk("reset_dbg", dbg_o, 32'h0);
        chk("reset_busy", DW'(rbusy), 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // Write then asynchronous reset between edges
        wr(0, 5, 32'hDEADBEEF); rdsel(0, 5);
        tick(); idle();
        chk("x5_written", rd[DW-1:0], 32'hDEADBEEF);
        iss_valid = 1'b1; iss_rd = 5'd6; rdsel(1, 6);
        tick(); idle();
        chk("x6_busy_pre_rst", DW'(rbusy[1]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_x5_zero", rd[DW-1:0], 32'h0);
        chk("rst_dbg_zero", dbg_o, 32'h0);
        chk("rst_busy_zero", DW'(rbusy), 32'h0);
        @(negedge clk); #2 rst_n = 1'b1;
        tick();

        // x0 protection
        wr(0, 0, 32'hFFFFFFFF); iss_valid = 1'b1; iss_rd = 5'd0; rdsel(0, 0);
        tick(); idle();
        chk("x0_rd", rd[DW-1:0], 32'h0);
        chk("x0_busy", DW'(rbusy[0]), 32'h0);

        // Write conflict, then write vs trigger
        wr(0, 7, 32'h11); wr(1, 7, 32'h22);
        tick(); idle(); rdsel(0, 7);
        #1 chk("x7_conflict", rd[DW-1:0], 32'h22);
        trigger = 1'b1; wr(0, 9, 32'h55);
        tick(); idle(); rdsel(1, 9);
        #1 chk("x9_write_over_trig", rd[2*DW-1:DW], 32'h55);
        trigger = 1'b1;
        tick(); idle();
        chk("x9_trigger", rd[2*DW-1:DW], 32'h1);

        // Scoreboard
        iss_valid = 1'b1; iss_rd = 5'd3; rdsel(0, 3);
        tick(); idle();
        chk("x3_busy_set", DW'(rbusy[0]), 32'h1);
        wr(1, 3, 32'h33);
        tick(); idle();
        chk("x3_busy_clr", DW'(rbusy[0]), 32'h0);
        iss_valid = 1'b1; iss_rd = 5'd3; wr(0, 3, 32'h44);
        tick(); idle();
        chk("x3_busy_tie", DW'(rbusy[0]), 32'h1);

        // Bypass / write-then-read timing
        wr(0, 4, 32'hBEEF); rdsel(0, 4);
        tick(); idle();
        wr(0, 4, 32'hCAFE);
        #1;
`ifdef RF_BYPASS_EN
        chk("x4_same_cycle", rd[DW-1:0], 32'hCAFE);
`else
        chk("x4_same_cycle", rd[DW-1:0], 32'hBEEF);
`endif
        tick(); idle();
        chk("x4_next_cycle", rd[DW-1:0], 32'hCAFE);

        // Debug tap
        wr(1, 10, 32'h1234);
        tick(); idle();
        chk("dbg_a0", dbg_o, 32'h1234);

        // Mixed traffic checked against the model each cycle
        for (int n = 0; n < 60; n++) begin
            we = NW'($urandom_range(0, 3));
            wa = NW*AW'($urandom_range(0, 15)) | (NW*AW'($urandom_range(0, 15)) << AW);
            wd = {$urandom(), $urandom()};
            ra = NR*AW'($urandom_range(0, 15)) | (NR*AW'($urandom_range(0, 15)) << AW);
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 15));
            trigger = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();
        @(negedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port integer register file for the pipelined successor of the single-cycle core.
- Generalises read/write port counts and widths, and adds a per-register busy scoreboard for hazard detection.
- Keeps the trigger-to-register event input and the a0 debug tap.
- Sits between decode (read, issue) and writeback (write ports).

Parameters:
- A_WIDTH, 5, register address width; depth = 2**A_WIDTH.
- D_WIDTH, 32, register data width.
- NR, 2, number of read ports (1..4).
- NW, 1, number of write ports (1..2).
- TRIG_REG, 9, register set to 1 by trigger.
- DBG_REG, 10, register exposed on dbg_o (a0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  NW  write enable per write port.
- wa  in  NW*A_WIDTH  write addresses, port k at [k*A_WIDTH +: A_WIDTH].
- wd  in  NW*D_WIDTH  write data, packed like wa.
- ra  in  NR*A_WIDTH  read addresses.
- rd  out  NR*D_WIDTH  read data.
- rbusy  out  NR  busy flag of each read address.
- iss_valid  in  1  instruction issued with a destination register.
- iss_rd  in  A_WIDTH  destination register of the issued instruction.
- trigger  in  1  event input; sets TRIG_REG to 1.
- dbg_o  out  D_WIDTH  current value of DBG_REG.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers go to 0 and all busy bits clear.
  - Outputs follow combinationally: rd = 0, rbusy = 0, dbg_o = 0.
  - Reset mid-operation discards writes in flight.
- x0:
  - Reads always return 0 and rbusy is always 0.
  - Writes, trigger and issue targeting x0 are ignored.
- Reads: combinational, zero latency, from array state (bypass: see Optional Feature).
- Writes:
  - Registered on the rising clk edge when we[k]=1 and wa[k]!=0.
  - Two ports writing the same address in one cycle: the higher port index wins.
- Trigger:
  - trigger=1 at an edge writes {D_WIDTH-1 zeros, 1} to TRIG_REG.
  - A same-cycle write port targeting TRIG_REG overrides the trigger.
- Scoreboard (one busy bit per register, 1..depth-1):
  - Set at the edge when iss_valid=1 and iss_rd!=0.
  - Cleared at the edge when any write port writes that register.
  - Same-cycle set and clear of one register: set wins (a new producer supersedes the retiring one).
  - Trigger does not affect busy bits.
- rbusy[i]: combinational busy bit of ra[i]; reflects registered state only.
- dbg_o: combinational view of the array entry DBG_REG; not bypassed.
- Width: data is stored unmodified. Out-of-range parameters fail elaboration via $error.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - A read whose address matches an active write port (non-zero address) returns that port's wd in the same cycle.
  - Multiple matches resolve to the highest port index.
  - rbusy for that read is forced to 0.
  - A pending trigger is also forwarded to reads of TRIG_REG unless overridden by a write.
- Undefined: reads return pre-edge array contents; the new value is visible the cycle after the write.

Decomposition:
- Package rf_pkg: A_WIDTH_DEF, D_WIDTH_DEF, REG_ZERO=0, REG_RA=1, REG_S1=9, REG_A0=10, typedef reg_addr_t, typedef reg_data_t.
- Sub-module rf_scoreboard: busy-bit vector with set/clear priority and NR combinational lookups.
- rf_mp holds the storage array, write arbitration, trigger and bypass muxing.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse rst_n low between edges -> rd for x5 = 0 immediately; dbg_o = 0; all rbusy = 0.
- x0 protection: we=1, wa=0, wd=0xFFFFFFFF; iss_valid with iss_rd=0 -> reading x0 returns 0 and rbusy=0.
- Write conflict (NW=2): both ports write x7, port0 0x11, port1 0x22 -> x7 = 0x22 next cycle. With trigger and a write of 0x55 to x9 in the same cycle -> x9 = 0x55.
- Scoreboard:
  - Issue x3 -> rbusy=1 next cycle.
  - Write x3 -> rbusy=0 the following cycle.
  - Issue x3 and write x3 in the same cycle -> rbusy stays 1.
- Bypass:
  - With RF_BYPASS_EN: write x4=0xCAFE while reading x4 -> rd=0xCAFE in the same cycle.
  - Without RF_BYPASS_EN: rd = old value, then 0xCAFE the next cycle.
- Trigger/debug: pulse trigger -> x9 = 0x1 next cycle. Write x10=0x1234 -> dbg_o = 0x1234 after the edge.
